// File: rtl/ce_rw_fifo.sv
// Chip-enabled synchronous FIFO with occupancy count, sticky overflow/underflow flags and registered read data.
// Optional protocol assertions are compiled in when CE_RW_FIFO_SVA_EN is defined.
module ce_rw_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             wr,
  input  logic             rd,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  assign rd_acc = ce & rd & ~empty;
  assign wr_acc = ce & wr & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    rd_valid_d  = rd_acc;
    overflow_d  = (ce & wr & full & ~rd_acc) | (overflow_q & ~clr);
    underflow_d = (ce & rd & empty) | (underflow_q & ~clr);

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  assign dout      = dout_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef CE_RW_FIFO_SVA_EN
  a_count_le_depth: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(DEPTH))
    else $error("a_count_le_depth failed at %0t", $time);

  a_rd_valid_cause: assert property (@(posedge clk) disable iff (!rst)
    rd_valid_q |-> $past(ce & rd & ~empty))
    else $error("a_rd_valid_cause failed at %0t", $time);

  a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst)
    !(full && empty))
    else $error("a_full_empty_excl failed at %0t", $time);

  a_reset_empty: assert property (@(posedge clk) disable iff (!rst)
    $rose(rst) |-> (empty && count_q == '0))
    else $error("a_reset_empty failed at %0t", $time);
`else
`endif

endmodule

// File: tb/tb_ce_rw_fifo.sv
// Scoreboard bench for ce_rw_fifo (WIDTH=8, DEPTH=4): a queue model predicts every cycle's outputs.
module tb_ce_rw_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ce = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             rd_valid, full, empty, overflow, underflow;
  logic [CW-1:0]    count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned mq[$];     // model FIFO contents
  int unsigned exp_q[$];  // scoreboard of expected read data
  int unsigned m_dout = 0;
  bit          m_ovf = 0, m_unf = 0;

  ce_rw_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .wr(wr), .rd(rd), .clr(clr), .din(din),
    .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("ovf", overflow, m_ovf);
    chk("unf", underflow, m_unf);
    chk("dout", dout, m_dout);
  endtask

  // Drive one cycle's inputs, predict, then check #1 after the edge.
  task automatic step(input bit c, input bit w, input bit r, input bit cl, input int unsigned d);
    bit rda, wra, fl, em;
    ce = c; wr = w; rd = r; clr = cl; din = WIDTH'(d);
    fl  = (mq.size() == DEPTH);
    em  = (mq.size() == 0);
    rda = c && r && !em;
    wra = c && w && (!fl || rda);
    m_ovf = (c && w && fl && !rda) || (m_ovf && !cl);
    m_unf = (c && r && em) || (m_unf && !cl);
    if (rda) exp_q.push_back(mq.pop_front());
    if (wra) mq.push_back(d);
    @(posedge clk);
    #1;
    ce = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
    chk("rd_valid", rd_valid, rda);
    if (rda) begin
      m_dout = exp_q.pop_front();
      chk("rdata", dout, m_dout);
    end
    chk_state();
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_dout = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  initial begin
    int unsigned fill[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    #1 rst = 1'b0;
    #30 rst = 1'b1;
    #1;
    chk("rst_rv", rd_valid, 0);
    chk_state();

    // Write strobe without chip enable is ignored
    step(0, 1, 0, 0, 8'h11);
    step(0, 1, 1, 0, 8'h12);

    // Fill and drain
    foreach (fill[i]) step(1, 1, 0, 0, fill[i]);
    chk("full4", full, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
    chk("empty0", empty, 1);

    // Overflow, then drain (0xEE must not appear)
    foreach (fill[i]) step(1, 1, 0, 0, fill[i] + 1);
    step(1, 1, 0, 0, 8'hEE);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);

    // Pointer wrap: six write/read pairs
    for (int unsigned i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, 8'h30 + i);
      step(1, 0, 1, 0, 0);
    end
    step(0, 0, 0, 1, 0);
    chk("ovf_clr", overflow, 0);

    // Simultaneous wr/rd while full
    foreach (fill[i]) step(1, 1, 0, 0, fill[i]);
    step(1, 1, 1, 0, 8'h55);
    chk("sim_full_dout", dout, 8'hA1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);

    // Simultaneous wr/rd while empty
    step(1, 1, 1, 0, 8'h66);
    chk("sim_empty_unf", underflow, 1);
    // clr loses to a new underflow in the same cycle
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 8'h67);
    step(1, 1, 0, 0, 8'h68);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    chk("clr_vs_set", underflow, 1);
    step(0, 0, 0, 1, 0);

    // Async reset mid-stream, with rd_valid high when it hits
    step(1, 1, 0, 0, 8'h70);
    step(1, 1, 0, 0, 8'h71);
    step(1, 1, 0, 0, 8'h72);
    step(1, 1, 1, 0, 8'h73);
    chk("pre_rst_cnt", count, 3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_rv", rd_valid, 0);
    chk_state();
    #2 rst = 1'b1;
    step(1, 1, 0, 0, 8'h77);
    step(1, 0, 1, 0, 0);
    chk("post_rst_data", dout, 8'h77);

    // Random traffic against the model
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), $urandom_range(0, 255));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ce_rw_fifo.md
Name: ce_rw_fifo

Overview:
- Parametrised chip-enabled storage block with write/read strobes (ce, wr, rd), generalised from a single-cycle ce&&wr / ce&&rd control check into a real buffer.
- Synchronous FIFO of configurable width and depth, with occupancy count, full/empty flags, sticky overflow/underflow error flags and registered read data.
- Sits between a command producer driving ce/wr/rd and a consumer sampling dout/rd_valid.
- Compile-time SVA protocol checks are optional.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- CW, $clog2(DEPTH)+1, count width (derived localparam; not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- ce  input  1  chip enable; no operation is accepted unless ce=1.
- wr  input  1  write strobe, qualified by ce.
- rd  input  1  read strobe, qualified by ce.
- clr  input  1  synchronous clear of the sticky error flags only.
- din  input  WIDTH  write data.
- dout  output  WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse: dout holds newly read data.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full and no read accepted in the same cycle.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, rd_valid=0, overflow=0, underflow=0, empty=1, full=0. Memory contents are not cleared.
- Reset released mid-operation: the first clock edge with rst=1 is a normal cycle.
- Qualification: wr_acc = ce & wr & (!full | rd_acc); rd_acc = ce & rd & !empty.
- ce=0: no pointer, count or memory change; rd_valid=0; dout holds its value; error flags hold unless clr=1.
- Write: on wr_acc, mem[wr_ptr]<=din and wr_ptr<=wr_ptr+1 mod DEPTH (natural wrap).
- Read: on rd_acc, dout<=mem[rd_ptr] and rd_ptr<=rd_ptr+1 mod DEPTH. Latency 1: rd_valid=1 in the cycle after the accepting edge, otherwise 0.
- Count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. full and empty decode combinationally from the registered count.
- Simultaneous wr&rd while full: both accepted, count stays DEPTH, no overflow.
- Simultaneous wr&rd while empty: write accepted, read rejected, underflow<=1, count becomes 1, rd_valid=0 next cycle.
- Error flags: overflow<=1 on ce&wr&full&!rd_acc; underflow<=1 on ce&rd&empty. Flags are sticky until rst=0 or clr=1.
- clr and a new error in the same cycle: the set wins (flag stays 1).
- Rejected operations never modify pointers, count or memory.

Optional Feature:
- Macro: CE_RW_FIFO_SVA_EN.
- Defined: embedded concurrent assertions on posedge clk, disabled while rst=0:
  - (a) count never exceeds DEPTH.
  - (b) rd_valid implies $past(ce&rd&!empty).
  - (c) full and empty are never both 1.
  - (d) $rose(rst) |-> empty && count==0.
  Each assertion reports via $error with its name and $time.
- Undefined: no assertion code; ports and behaviour are identical.

Test Plan (WIDTH=8, DEPTH=4):
- Reset release: rst=0 for 30ns, then 1 with ce=0 -> empty=1, full=0, count=0, dout=0, flags=0. Pulse wr with ce=0 -> count stays 0.
- Fill/drain: ce=1, write 0xA1,0xB2,0xC3,0xD4 -> full=1, count=4. Read 4 times -> dout=0xA1,0xB2,0xC3,0xD4, each with rd_valid one cycle after the strobe; empty=1 after the last read.
- Overflow and wrap: from full, wr alone with din=0xEE -> overflow=1, count=4, 0xEE absent on drain. Then write/read 6 more values (pointer wrap) -> order preserved. clr=1 -> overflow=0.
- Simultaneous at boundaries: full with wr=rd=1, din=0x55 -> count=4, dout=0xA1 (oldest), no overflow. Empty with wr=rd=1, din=0x66 -> count=1, underflow=1, rd_valid=0.
- Async reset mid-stream: count=3, drop rst between edges -> count=0, empty=1, rd_valid=0 immediately (before the next edge). Next write/read returns the new data.
- With CE_RW_FIFO_SVA_EN defined: all runs above complete with zero assertion failures.
